// File: rtl/icache_ctrl.sv
// Direct-mapped instruction cache controller: combinational hits, in-order whole-line
// refill from async-read instruction memory on a miss, flush, and hit/miss statistics.
module icache_ctrl #(
  parameter int LINE_WORDS = 4,
  parameter int NUM_LINES  = 8,
  parameter int MEM_LAT    = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic [7:0]  cpu_addr,
  input  logic        flush,
  output logic [15:0] cpu_rdata,
  output logic        cpu_stall,
  output logic [7:0]  mem_addr,
  input  logic [15:0] mem_rdata,
  output logic [15:0] hit_cnt,
  output logic [15:0] miss_cnt
);
  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = 8 - OFF_W - IDX_W;
  localparam logic [OFF_W-1:0] WORD_LAST = OFF_W'(LINE_WORDS - 1);
  localparam logic [3:0]       LAT_LAST  = 4'(MEM_LAT - 1);

  typedef enum logic {S_LOOKUP, S_FILL} state_e;

  state_e               state_q, state_d;
  logic [NUM_LINES-1:0] valid_q, valid_d;
  logic                 flush_pending_q, flush_pending_d;
  logic                 replay_q, replay_d;
  logic [OFF_W-1:0]     wcnt_q, wcnt_d;
  logic [3:0]           lcnt_q, lcnt_d;
  logic [TAG_W-1:0]     rtag_q, rtag_d;
  logic [IDX_W-1:0]     ridx_q, ridx_d;
  logic [15:0]          hit_cnt_q, hit_cnt_d;
  logic [15:0]          miss_cnt_q, miss_cnt_d;

  logic [15:0]      data_q [NUM_LINES*LINE_WORDS];
  logic [TAG_W-1:0] tag_q  [NUM_LINES];

  logic [OFF_W-1:0] addr_off;
  logic [IDX_W-1:0] addr_idx;
  logic [TAG_W-1:0] addr_tag;
  assign addr_off = cpu_addr[OFF_W-1:0];
  assign addr_idx = cpu_addr[OFF_W +: IDX_W];
  assign addr_tag = cpu_addr[7 -: TAG_W];

  logic in_lookup, do_flush, lookup_hit, lookup_miss, word_done, line_done;
  always_comb begin
    in_lookup   = (state_q == S_LOOKUP);
    do_flush    = in_lookup && (flush || flush_pending_q);
    lookup_hit  = in_lookup && !do_flush && cpu_req &&
                  valid_q[addr_idx] && (tag_q[addr_idx] == addr_tag);
    lookup_miss = in_lookup && !do_flush && cpu_req && !lookup_hit;
    word_done   = !in_lookup && (lcnt_q == LAT_LAST);
    line_done   = word_done && (wcnt_q == WORD_LAST);
  end

  // NOTE: sequential state uses non-blocking assignments only; all next values come from *_d.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q         <= S_LOOKUP;
      valid_q         <= '0;
      flush_pending_q <= 1'b0;
      replay_q        <= 1'b0;
      wcnt_q          <= '0;
      lcnt_q          <= '0;
      rtag_q          <= '0;
      ridx_q          <= '0;
      hit_cnt_q       <= '0;
      miss_cnt_q      <= '0;
    end else begin
      state_q         <= state_d;
      valid_q         <= valid_d;
      flush_pending_q <= flush_pending_d;
      replay_q        <= replay_d;
      wcnt_q          <= wcnt_d;
      lcnt_q          <= lcnt_d;
      rtag_q          <= rtag_d;
      ridx_q          <= ridx_d;
      hit_cnt_q       <= hit_cnt_d;
      miss_cnt_q      <= miss_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_LOOKUP: if (lookup_miss) state_d = S_FILL;
      S_FILL:   if (line_done)   state_d = S_LOOKUP;
    endcase
  end

  // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latches).
  always_comb begin
    valid_d         = valid_q;
    flush_pending_d = flush_pending_q;
    replay_d        = replay_q;
    wcnt_d          = wcnt_q;
    lcnt_d          = lcnt_q;
    rtag_d          = rtag_q;
    ridx_d          = ridx_q;
    hit_cnt_d       = hit_cnt_q;
    miss_cnt_d      = miss_cnt_q;
    if (in_lookup) begin
      replay_d = 1'b0;
      if (do_flush) begin
        valid_d         = '0;
        flush_pending_d = 1'b0;
      end
      // The replay hit belongs to a fetch already counted as a miss.
      if (lookup_hit && !replay_q && hit_cnt_q != 16'hFFFF) hit_cnt_d = hit_cnt_q + 16'd1;
      if (lookup_miss) begin
        if (miss_cnt_q != 16'hFFFF) miss_cnt_d = miss_cnt_q + 16'd1;
        rtag_d = addr_tag;
        ridx_d = addr_idx;
        wcnt_d = '0;
        lcnt_d = '0;
      end
    end else begin
      if (flush) flush_pending_d = 1'b1;
      lcnt_d = word_done ? 4'd0 : lcnt_q + 4'd1;
      if (word_done) wcnt_d = wcnt_q + OFF_W'(1);
      if (line_done) begin
        valid_d[ridx_q] = 1'b1;
        replay_d        = 1'b1;
      end
    end
  end

  // NOTE: the data and tag arrays have no reset; the valid bits alone decide whether they are used.
  always_ff @(posedge clock) begin
    if (reset && word_done) data_q[{ridx_q, wcnt_q}] <= mem_rdata;
    if (reset && line_done) tag_q[ridx_q] <= rtag_q;
  end

  always_comb begin
    cpu_stall = 1'b0;
    cpu_rdata = '0;
    mem_addr  = cpu_addr;
    if (!reset) begin
      mem_addr = '0;
    end else if (in_lookup) begin
      cpu_stall = do_flush || lookup_miss;
      if (lookup_hit) cpu_rdata = data_q[{addr_idx, addr_off}];
    end else begin
      cpu_stall = 1'b1;
      mem_addr  = {rtag_q, ridx_q, wcnt_q};
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
endmodule

// File: tb/tb_icache_ctrl.sv
// Scoreboard bench for icache_ctrl: default instance (MEM_LAT=1) and a MEM_LAT=3 instance,
// checked one at a time against a line-residency model of a direct-mapped cache.
module tb_icache_ctrl;
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset, cpu_req, flush;
  logic [7:0]  cpu_addr;
  logic [15:0] rdata_a, rdata_b, hit_a, hit_b, miss_a, miss_b, mrd_a, mrd_b;
  logic        stall_a, stall_b;
  logic [7:0]  maddr_a, maddr_b;
  bit          sel = 1'b0;

  logic [15:0] cpu_rdata, hit_cnt, miss_cnt;
  logic        cpu_stall;
  logic [7:0]  mem_addr;

  assign mrd_a     = {8'hA5, maddr_a};
  assign mrd_b     = {8'hA5, maddr_b};
  assign cpu_rdata = sel ? rdata_b : rdata_a;
  assign cpu_stall = sel ? stall_b : stall_a;
  assign mem_addr  = sel ? maddr_b : maddr_a;
  assign hit_cnt   = sel ? hit_b   : hit_a;
  assign miss_cnt  = sel ? miss_b  : miss_a;

  icache_ctrl #(.LINE_WORDS(4), .NUM_LINES(8), .MEM_LAT(1)) dut_a (
    .clock(clock), .reset(reset), .cpu_req(cpu_req), .cpu_addr(cpu_addr), .flush(flush),
    .cpu_rdata(rdata_a), .cpu_stall(stall_a), .mem_addr(maddr_a), .mem_rdata(mrd_a),
    .hit_cnt(hit_a), .miss_cnt(miss_a));

  icache_ctrl #(.LINE_WORDS(4), .NUM_LINES(8), .MEM_LAT(3)) dut_b (
    .clock(clock), .reset(reset), .cpu_req(cpu_req), .cpu_addr(cpu_addr), .flush(flush),
    .cpu_rdata(rdata_b), .cpu_stall(stall_b), .mem_addr(maddr_b), .mem_rdata(mrd_b),
    .hit_cnt(hit_b), .miss_cnt(miss_b));

  typedef struct {
    bit         is_flush;
    logic [7:0] addr;
    int         stall;
    bit         chk_addr;
    int         hits;
    int         misses;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   line_at[8];
  int   m_hits, m_miss;
  int   n_checks = 0, n_err = 0;
  int   stall_run = 0;
  bit   rst_seen = 1'b0;

  function automatic int lat();
    return sel ? 3 : 1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit resident(input logic [7:0] a);
    int line;
    line = int'(a) / 4;
    return line_at[line % 8] == line;
  endfunction

  task automatic model_reset();
    foreach (line_at[i]) line_at[i] = -1;
    m_hits = 0;
    m_miss = 0;
  endtask

  // Expected outcome of one fetch; counts are as visible on the fetch's data cycle.
  task automatic expect_fetch(input logic [7:0] a, input bit mid_flush);
    exp_t e;
    int   line, fill;
    line       = int'(a) / 4;
    fill       = 1 + 4 * lat();
    e.is_flush = 1'b0;
    e.addr     = a;
    e.chk_addr = !mid_flush;
    if (resident(a) && !mid_flush) begin
      e.stall = 0;
      e.hits  = m_hits;
      m_hits++;
    end else begin
      e.stall = mid_flush ? 2 * fill + 1 : fill;
      if (mid_flush) begin
        foreach (line_at[i]) line_at[i] = -1;
        m_miss += 2;
      end else begin
        m_miss += 1;
      end
      line_at[line % 8] = line;
      e.hits = m_hits;
    end
    e.misses = m_miss;
    sb.push_back(e);
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      stall_run = 0;
      check("rst_stall", 32'(cpu_stall), 32'd0);
      check("rst_rdata", 32'(cpu_rdata), 32'd0);
      check("rst_mem_addr", 32'(mem_addr), 32'd0);
      if (rst_seen) begin
        check("rst_hit_cnt", 32'(hit_cnt), 32'd0);
        check("rst_miss_cnt", 32'(miss_cnt), 32'd0);
      end
      rst_seen = 1'b1;
    end else begin
      rst_seen = 1'b0;
      if (cpu_stall) begin
        check("stall_rdata", 32'(cpu_rdata), 32'd0);
        if (sb.size() > 0 && sb[0].chk_addr && stall_run >= 1)
          check("fill_mem_addr", 32'(mem_addr),
                32'((int'(sb[0].addr) / 4) * 4 + (stall_run - 1) / lat()));
        stall_run++;
      end else if (cpu_req || stall_run > 0) begin
        check("sb_pending", 32'(sb.size() > 0), 32'd1);
        if (sb.size() > 0) begin
          cur = sb.pop_front();
          check("stall_len", 32'(stall_run), 32'(cur.stall));
          if (cur.is_flush) begin
            check("flush_rdata", 32'(cpu_rdata), 32'd0);
          end else begin
            check("fetch_rdata", 32'(cpu_rdata), 32'({8'hA5, cur.addr}));
            check("lookup_mem_addr", 32'(mem_addr), 32'(cpu_addr));
          end
          check("hit_cnt", 32'(hit_cnt), 32'(cur.hits));
          check("miss_cnt", 32'(miss_cnt), 32'(cur.misses));
        end
        stall_run = 0;
      end else begin
        check("idle_rdata", 32'(cpu_rdata), 32'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    @(negedge clock);
    while (cpu_stall && n < 200) begin
      @(negedge clock);
      n++;
    end
    if (n >= 200) check("stall_timeout", 32'(cpu_stall), 32'd0);
    tick();
  endtask

  task automatic fetch(input logic [7:0] a);
    expect_fetch(a, 1'b0);
    cpu_req  = 1'b1;
    cpu_addr = a;
    wait_done();
  endtask

  task automatic fetch_midflush(input logic [7:0] a);
    expect_fetch(a, 1'b1);
    cpu_req  = 1'b1;
    cpu_addr = a;
    tick();
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    wait_done();
  endtask

  task automatic flush_lookup();
    exp_t e;
    e.is_flush = 1'b1;
    e.addr     = 8'h00;
    e.stall    = 1;
    e.chk_addr = 1'b0;
    e.hits     = m_hits;
    e.misses   = m_miss;
    sb.push_back(e);
    foreach (line_at[i]) line_at[i] = -1;
    cpu_req = 1'b0;
    flush   = 1'b1;
    tick();
    flush = 1'b0;
    tick();
  endtask

  task automatic do_reset();
    reset   = 1'b0;
    cpu_req = 1'b0;
    flush   = 1'b0;
    tick();
    tick();
    tick();
    sb.delete();
    model_reset();
    reset = 1'b1;
  endtask

  // Reset lands after two words of a refill; the same fetch must then refill completely.
  task automatic reset_midfill(input logic [7:0] a);
    cpu_req  = 1'b1;
    cpu_addr = a;
    tick();
    tick();
    tick();
    reset = 1'b0;
    tick();
    tick();
    sb.delete();
    model_reset();
    expect_fetch(a, 1'b0);
    reset = 1'b1;
    wait_done();
  endtask

  task automatic random_ops(input int n);
    for (int i = 0; i < n; i++) begin
      int         r;
      logic [7:0] a;
      r = int'($urandom_range(0, 15));
      a = 8'($urandom_range(0, 63));
      if (r == 0) flush_lookup();
      else if (r == 1 && !resident(a)) fetch_midflush(a);
      else if (r == 2) begin
        cpu_req = 1'b0;
        tick();
      end else fetch(a);
    end
  endtask

  initial begin
    reset    = 1'b0;
    cpu_req  = 1'b0;
    flush    = 1'b0;
    cpu_addr = 8'h00;
    model_reset();
    do_reset();

    fetch(8'h06);
    fetch(8'h04);
    fetch(8'h05);
    fetch(8'h07);
    fetch(8'h26);
    fetch(8'h06);
    flush_lookup();
    fetch(8'h00);
    fetch(8'h01);
    fetch_midflush(8'h48);
    fetch(8'h49);
    reset_midfill(8'h30);
    fetch(8'h33);
    random_ops(150);

    sel = 1'b1;
    do_reset();
    fetch(8'h10);
    fetch(8'h13);
    fetch_midflush(8'h2C);
    random_ops(40);

    cpu_req = 1'b0;
    tick();
    @(negedge clock);
    check("final_hit_cnt", 32'(hit_cnt), 32'(m_hits));
    check("final_miss_cnt", 32'(miss_cnt), 32'(m_miss));
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
